// File: rtl/player_pkg.sv
// Shared types, default constants and tile-index helper for the player controller
// and other playfield actors.
package player_pkg;

    typedef enum logic [2:0] {
        st_spawn, st_idle, st_walk, st_dying, st_penalty, st_over
    } pstate_t;

    localparam int DEF_MIN_X   = 100;
    localparam int DEF_MAX_X   = 739;
    localparam int DEF_MIN_Y   = 65;
    localparam int DEF_MAX_Y   = 448;
    localparam int DEF_P_W     = 32;
    localparam int DEF_P_H     = 32;
    localparam int DEF_SPAWN_X = 292;
    localparam int DEF_SPAWN_Y = 400;
    localparam int DEF_TILES   = 8;
    localparam int DEF_FRAMES  = 5;

    function automatic logic [1:0] anim_row(input pstate_t s);
        case (s)
            st_walk:    return 2'd1;
            st_dying:   return 2'd2;
            st_penalty: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    // Sprite sheet is laid out row-major: animation row, then tile, then carried-item variant.
    function automatic logic [6:0] tile_index(input logic [1:0] row, input int tile,
                                              input int items, input int tiles, input int slots);
        return 7'(int'(row) * tiles * slots + tile * slots + items);
    endfunction

endpackage

// File: rtl/player_ctrl_anim_counter.sv
// Frame/tile divider: frame counter wraps every FRAMES ticks and advances a tile
// counter that wraps every TILES; hold freezes the tile counter only.
module anim_counter #(
    parameter int FRAMES = 5,
    parameter int TILES  = 8,
    parameter int FW     = $clog2(FRAMES + 1),
    parameter int TW     = $clog2(TILES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          hold,
    output logic [TW-1:0] tile,
    output logic          frame_wrap,
    output logic          tile_wrap
);

    logic [FW-1:0] frame;

    assign frame_wrap = (frame == FW'(FRAMES - 1));
    assign tile_wrap  = frame_wrap && (tile == TW'(TILES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            frame <= '0;
            tile  <= '0;
        end else begin
            frame <= frame_wrap ? '0 : frame + 1'b1;
            if (frame_wrap && !hold)
                tile <= tile_wrap ? '0 : tile + 1'b1;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Per-player controller: movement with clamping, carry/deposit scoring, hit/death
// sequencing with lives, respawn invulnerability and sprite addressing.
module player_ctrl
    import player_pkg::*;
#(
    parameter int MAX_ITEMS       = 3,
    parameter int TILES_PER_ANIM  = DEF_TILES,
    parameter int FRAMES_PER_TILE = DEF_FRAMES,
    parameter int DEATH_TILES     = 60,
    parameter int INVULN_FRAMES   = 90,
    parameter int LIVES           = 3,
    parameter int MOVE_DIV        = 2,
    parameter int MIN_X           = DEF_MIN_X,
    parameter int MAX_X           = DEF_MAX_X,
    parameter int MIN_Y           = DEF_MIN_Y,
    parameter int MAX_Y           = DEF_MAX_Y,
    parameter int P_W             = DEF_P_W,
    parameter int P_H             = DEF_P_H,
    parameter int SPAWN_X         = DEF_SPAWN_X,
    parameter int SPAWN_Y         = DEF_SPAWN_Y,
    parameter int SCORE_W         = 7
) (
    input  logic               FrameClk,
    input  logic               Reset,
    input  logic               SpawnEnable,
    input  logic               FaceLeftInit,
    input  logic               Left,
    input  logic               Right,
    input  logic               Up,
    input  logic               Down,
    input  logic               Hit,
    input  logic [1:0]         Collect,
    input  logic               Deposit,
    input  logic [2:0]         Speed,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic               PlayerPixel,
    output logic [6:0]         Tile,
    output logic [4:0]         PixelX,
    output logic [4:0]         PixelY,
    output logic [9:0]         PlayerX,
    output logic [9:0]         PlayerY,
    output logic               Dead,
    output logic               Invuln,
    output logic               Full,
    output logic               GameOver,
    output logic [2:0]         Lives,
    output logic [SCORE_W-1:0] Score
);

    localparam int TW   = $clog2(TILES_PER_ANIM + 1);
    localparam int NW   = $clog2(INVULN_FRAMES + 1);
    localparam int MW   = $clog2(MOVE_DIV + 1);
    localparam int PW   = $clog2(DEATH_TILES + 1);
    localparam int VW   = 5;
    localparam int SUMW = SCORE_W + 6;
    localparam int SMAX = (1 << SCORE_W) - 1;

    pstate_t state, state_n;
    logic [9:0] x, x_n, y, y_n, x_dec, x_inc, y_dec, y_inc;
    logic [10:0] step, xs, ys, dx, dy;
    logic facing, facing_n, restart, restart_n;
    logic [2:0] items, items_n, lives, lives_n;
    logic [VW-1:0] value, value_n;
    logic [SCORE_W-1:0] score, score_n, score_sat;
    logic [SUMW-1:0] sum;
    logic [NW-1:0] invuln, invuln_n;
    logic [MW-1:0] mv, mv_n;
    logic [PW-1:0] pen, pen_n;
    logic [TW-1:0] tile;
    logic anim_clr, anim_hold, frame_wrap, tile_wrap, fire, take, active;

    anim_counter #(.FRAMES(FRAMES_PER_TILE), .TILES(TILES_PER_ANIM)) u_anim (
        .clk(FrameClk), .rst(Reset), .clr(anim_clr), .hold(anim_hold),
        .tile(tile), .frame_wrap(frame_wrap), .tile_wrap(tile_wrap)
    );

    // Heavier loads slow the player, but never to a standstill.
    assign step  = (Speed > items) ? 11'(Speed - items) : 11'd1;
    assign xs    = {1'b0, x} + step;
    assign ys    = {1'b0, y} + step;
    assign x_dec = ({1'b0, x} < 11'(MIN_X) + step) ? 10'(MIN_X) : 10'({1'b0, x} - step);
    assign y_dec = ({1'b0, y} < 11'(MIN_Y) + step) ? 10'(MIN_Y) : 10'({1'b0, y} - step);
    assign x_inc = (xs > 11'(MAX_X - P_W)) ? 10'(MAX_X - P_W) : xs[9:0];
    assign y_inc = (ys > 11'(MAX_Y - P_H)) ? 10'(MAX_Y - P_H) : ys[9:0];

    assign fire      = (mv == MW'(MOVE_DIV - 1));
    assign take      = (Collect != 2'd0) && (items < 3'(MAX_ITEMS));
    assign sum       = SUMW'(score) + SUMW'(value) + SUMW'(take ? Collect : 2'd0);
    assign score_sat = (sum > SUMW'(SMAX)) ? SCORE_W'(SMAX) : sum[SCORE_W-1:0];

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        facing_n  = facing;
        items_n   = items;
        value_n   = value;
        score_n   = score;
        lives_n   = lives;
        invuln_n  = invuln;
        mv_n      = mv;
        pen_n     = pen;
        restart_n = restart;
        anim_clr  = 1'b0;
        anim_hold = (state == st_penalty);
        if (!SpawnEnable) begin
            state_n   = st_spawn;
            restart_n = 1'b1;
            anim_clr  = 1'b1;
        end else begin
            case (state)
                st_spawn: begin
                    x_n      = 10'(SPAWN_X);
                    y_n      = 10'(SPAWN_Y);
                    facing_n = FaceLeftInit;
                    items_n  = '0;
                    value_n  = '0;
                    invuln_n = NW'(INVULN_FRAMES);
                    mv_n     = '0;
                    pen_n    = '0;
                    anim_clr = 1'b1;
                    if (restart) begin
                        score_n   = '0;
                        lives_n   = 3'(LIVES);
                        restart_n = 1'b0;
                    end
                    state_n = st_idle;
                end
                st_idle, st_walk: begin
                    if (invuln != '0)
                        invuln_n = invuln - 1'b1;
                    if (Hit && invuln == '0) begin
                        state_n  = st_dying;
                        anim_clr = 1'b1;
                        items_n  = '0;
                        value_n  = '0;
                        lives_n  = lives - 1'b1;
                        pen_n    = '0;
                    end else begin
                        mv_n = fire ? '0 : mv + 1'b1;
                        if (fire) begin
                            if (Left ^ Right) begin
                                x_n      = Left ? x_dec : x_inc;
                                facing_n = Left;
                            end
                            if (Up ^ Down)
                                y_n = Up ? y_dec : y_inc;
                            state_n = ((Left ^ Right) || (Up ^ Down)) ? st_walk : st_idle;
                        end
                        if (take) begin
                            items_n = items + 1'b1;
                            value_n = value + VW'(Collect);
                        end
                        if (Deposit) begin
                            score_n = score_sat;
                            items_n = '0;
                            value_n = '0;
                        end
                    end
                end
                st_dying: begin
                    // Freeze on the final death tile for the whole penalty.
                    if (tile_wrap) begin
                        state_n   = st_penalty;
                        anim_hold = 1'b1;
                    end
                end
                st_penalty: begin
                    if (frame_wrap) begin
                        if (pen == PW'(DEATH_TILES - 1))
                            state_n = (lives != 3'd0) ? st_spawn : st_over;
                        else
                            pen_n = pen + 1'b1;
                    end
                end
                st_over: ;
                default: state_n = st_spawn;
            endcase
        end
    end

    always_ff @(posedge FrameClk) begin
        if (Reset) begin
            state   <= st_spawn;
            x       <= 10'(SPAWN_X);
            y       <= 10'(SPAWN_Y);
            facing  <= 1'b0;
            items   <= '0;
            value   <= '0;
            score   <= '0;
            lives   <= 3'(LIVES);
            invuln  <= '0;
            mv      <= '0;
            pen     <= '0;
            restart <= 1'b0;
        end else begin
            state   <= state_n;
            x       <= x_n;
            y       <= y_n;
            facing  <= facing_n;
            items   <= items_n;
            value   <= value_n;
            score   <= score_n;
            lives   <= lives_n;
            invuln  <= invuln_n;
            mv      <= mv_n;
            pen     <= pen_n;
            restart <= restart_n;
        end
    end

    assign active      = (state != st_spawn) && (state != st_over);
    assign dx          = {1'b0, DrawX} - {1'b0, x};
    assign dy          = {1'b0, DrawY} - {1'b0, y};
    assign PlayerPixel = active && (DrawX >= x) && (dx < 11'(P_W)) && (DrawY >= y) && (dy < 11'(P_H));
    assign PixelX      = facing ? 5'(P_W - 1) - dx[4:0] : dx[4:0];
    assign PixelY      = dy[4:0];
    assign Tile        = tile_index(anim_row(state), int'(tile), int'(items), TILES_PER_ANIM, MAX_ITEMS + 1);
    assign PlayerX     = x;
    assign PlayerY     = y;
    assign Dead        = (state == st_dying) || (state == st_penalty);
    assign Invuln      = (invuln != '0);
    assign Full        = (items == 3'(MAX_ITEMS));
    assign GameOver    = (state == st_over);
    assign Lives       = lives;
    assign Score       = score;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed and randomized bench for player_ctrl against a frame-level behavioural model.
module tb_player_ctrl;

    localparam int MAX_ITEMS = 3, LIVES = 3, MOVE_DIV = 2, INV = 90, SMAX = 127;
    localparam int DIE_FRAMES = 8 * 5, PEN_FRAMES = 60 * 5;
    localparam int M_SPAWN = 0, M_IDLE = 1, M_WALK = 2, M_DYING = 3, M_PENALTY = 4, M_OVER = 5;

    logic FrameClk = 1'b0;
    always #5 FrameClk = ~FrameClk;

    logic Reset, SpawnEnable, FaceLeftInit, Left, Right, Up, Down, Hit, Deposit;
    logic [1:0] Collect;
    logic [2:0] Speed;
    logic [9:0] DrawX, DrawY;
    logic PlayerPixel, Dead, Invuln, Full, GameOver;
    logic [6:0] Tile;
    logic [4:0] PixelX, PixelY;
    logic [9:0] PlayerX, PlayerY;
    logic [2:0] Lives;
    logic [6:0] Score;

    player_ctrl dut (
        .FrameClk(FrameClk), .Reset(Reset), .SpawnEnable(SpawnEnable), .FaceLeftInit(FaceLeftInit),
        .Left(Left), .Right(Right), .Up(Up), .Down(Down), .Hit(Hit), .Collect(Collect),
        .Deposit(Deposit), .Speed(Speed), .DrawX(DrawX), .DrawY(DrawY),
        .PlayerPixel(PlayerPixel), .Tile(Tile), .PixelX(PixelX), .PixelY(PixelY),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .Dead(Dead), .Invuln(Invuln), .Full(Full),
        .GameOver(GameOver), .Lives(Lives), .Score(Score)
    );

    int checks = 0, errors = 0;
    int m_mode, m_x, m_y, m_face, m_items, m_value, m_score, m_lives, m_inv, m_age, m_d, m_p, m_restart;
    int ref_x;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_edge();
        int step;
        bit moved;
        if (Reset) begin
            m_mode = M_SPAWN; m_x = 292; m_y = 400; m_face = 0; m_items = 0; m_value = 0;
            m_score = 0; m_lives = LIVES; m_inv = 0; m_age = 0; m_d = 0; m_p = 0; m_restart = 0;
        end else if (!SpawnEnable) begin
            m_mode = M_SPAWN; m_restart = 1;
        end else begin
            case (m_mode)
                M_SPAWN: begin
                    m_x = 292; m_y = 400; m_face = int'(FaceLeftInit);
                    m_items = 0; m_value = 0; m_inv = INV; m_age = 0;
                    if (m_restart != 0) begin m_score = 0; m_lives = LIVES; m_restart = 0; end
                    m_mode = M_IDLE;
                end
                M_IDLE, M_WALK: begin
                    if (Hit && m_inv == 0) begin
                        m_mode = M_DYING; m_d = 0; m_items = 0; m_value = 0; m_lives--;
                    end else begin
                        if (m_inv > 0) m_inv--;
                        if (m_age % MOVE_DIV == MOVE_DIV - 1) begin
                            step = (int'(Speed) - m_items > 1) ? int'(Speed) - m_items : 1;
                            moved = 0;
                            if (Left != Right) begin
                                m_x = clamp(Left ? m_x - step : m_x + step, 100, 739 - 32);
                                m_face = int'(Left); moved = 1;
                            end
                            if (Up != Down) begin
                                m_y = clamp(Up ? m_y - step : m_y + step, 65, 448 - 32);
                                moved = 1;
                            end
                            m_mode = moved ? M_WALK : M_IDLE;
                        end
                        m_age++;
                        if (Collect != 0 && m_items < MAX_ITEMS) begin m_items++; m_value += int'(Collect); end
                        if (Deposit) begin
                            m_score = (m_score + m_value > SMAX) ? SMAX : m_score + m_value;
                            m_items = 0; m_value = 0;
                        end
                    end
                end
                M_DYING:   if (m_d == DIE_FRAMES - 1) begin m_mode = M_PENALTY; m_p = 0; end else m_d++;
                M_PENALTY: if (m_p == PEN_FRAMES - 1) m_mode = (m_lives > 0) ? M_SPAWN : M_OVER; else m_p++;
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        bit act, pix;
        int et, dxv, px, py;
        logic [6:0] es;
        act = (m_mode >= M_IDLE && m_mode <= M_PENALTY);
        pix = act && int'(DrawX) >= m_x && int'(DrawX) < m_x + 32 && int'(DrawY) >= m_y && int'(DrawY) < m_y + 32;
        dxv = (int'(DrawX) - m_x) & 31;
        px  = (m_face != 0) ? 31 - dxv : dxv;
        py  = (int'(DrawY) - m_y) & 31;
        es  = {m_mode == M_DYING || m_mode == M_PENALTY, m_inv > 0, m_items == MAX_ITEMS,
               m_mode == M_OVER, 3'(m_lives)};
        chk("pos_x", 32'(PlayerX), m_x);
        chk("pos_y", 32'(PlayerY), m_y);
        chk("status", 32'({Dead, Invuln, Full, GameOver, Lives}), 32'(es));
        chk("score", 32'(Score), m_score);
        chk("pixel", 32'(PlayerPixel), 32'(pix));
        chk("pixel_xy", 32'({PixelX, PixelY}), 32'({5'(px), 5'(py)}));
        if (act) begin
            case (m_mode)
                M_IDLE:  et = ((m_age / 5) % 8) * 4 + m_items;
                M_WALK:  et = 32 + ((m_age / 5) % 8) * 4 + m_items;
                M_DYING: et = 64 + (m_d / 5) * 4;
                default: et = 96 + 7 * 4;
            endcase
            chk("tile", 32'(Tile), et);
        end
    endtask

    task automatic tick();
        @(posedge FrameClk);
        model_edge();
        #2;
        DrawX = 10'(m_x + int'($urandom_range(0, 40)) - 4);
        DrawY = 10'(m_y + int'($urandom_range(0, 40)) - 4);
        #1;
        check_all();
    endtask

    task automatic die_cycle();
        Hit = 0;
        repeat (95) tick();
        Hit = 1; tick(); Hit = 0;
        repeat (DIE_FRAMES + PEN_FRAMES) tick();
    endtask

    initial begin
        Reset = 1; SpawnEnable = 1; FaceLeftInit = 0; Left = 0; Right = 0; Up = 0; Down = 0;
        Hit = 0; Deposit = 0; Collect = 0; Speed = 4; DrawX = 0; DrawY = 0;
        repeat (2) tick();
        chk("reset_x", 32'(PlayerX), 292);
        chk("reset_lives", 32'(Lives), 3);
        chk("reset_pixel", 32'(PlayerPixel), 0);

        Reset = 0; Right = 1;
        repeat (11) tick();
        chk("walk_right_x", 32'(PlayerX), 312);
        chk("walk_row", 32'(Tile[6:5]), 1);
        Right = 0;
        repeat (2) tick();
        chk("release_idle_row", 32'(Tile[6:5]), 0);

        Hit = 1; tick(); Hit = 0;
        chk("hit_invuln_ignored", 32'(Dead), 0);

        Collect = 2; tick(); Collect = 1; tick(); tick(); Collect = 3; tick(); Collect = 0;
        chk("full_after_collect", 32'(Full), 1);
        ref_x = m_x;
        Right = 1; repeat (2) tick(); Right = 0;
        chk("full_step", 32'(PlayerX), ref_x + 1);
        Deposit = 1; tick(); Deposit = 0;
        chk("deposit_score", 32'(Score), 4);
        chk("deposit_empty", 32'(Full), 0);

        repeat (75) tick();
        Hit = 1; tick(); Hit = 0;
        chk("hit_dead", 32'(Dead), 1);
        chk("hit_lives", 32'(Lives), 2);
        repeat (DIE_FRAMES - 1) tick();
        chk("dying_row", 32'(Tile[6:5]), 2);
        tick();
        chk("penalty_tile", 32'(Tile), 124);
        repeat (PEN_FRAMES - 1) tick();
        chk("penalty_end_dead", 32'(Dead), 1);
        tick();
        chk("respawn_alive", 32'(Dead), 0);
        tick();
        chk("respawn_pos", 32'({PlayerX, PlayerY}), 32'({10'd292, 10'd400}));
        chk("respawn_score", 32'(Score), 4);

        Left = 1; Down = 1; Speed = 6;
        repeat (80) tick();
        chk("clamp_x", 32'(PlayerX), 100);
        chk("clamp_y", 32'(PlayerY), 416);
        Left = 0; Down = 0; Speed = 4;

        die_cycle();
        chk("second_death_lives", 32'(Lives), 1);
        die_cycle();
        chk("game_over", 32'(GameOver), 1);
        DrawX = PlayerX; DrawY = PlayerY; #1;
        chk("over_pixel", 32'(PlayerPixel), 0);
        repeat (5) tick();
        chk("over_terminal", 32'(GameOver), 1);

        SpawnEnable = 0; tick(); SpawnEnable = 1; tick();
        chk("restart_lives", 32'(Lives), 3);
        chk("restart_score", 32'(Score), 0);
        chk("restart_over", 32'(GameOver), 0);

        repeat (14) begin
            Collect = 3; tick(); tick();
            Deposit = 1; tick();
            Collect = 0; Deposit = 0;
        end
        chk("score_126", 32'(Score), 126);
        Collect = 2; tick();
        Collect = 3; Deposit = 1; tick();
        Collect = 0; Deposit = 0;
        chk("score_saturate", 32'(Score), 127);

        repeat (2500) begin
            Reset        = ($urandom_range(0, 499) == 0);
            SpawnEnable  = ($urandom_range(0, 299) != 0);
            FaceLeftInit = 1'($urandom_range(0, 1));
            Left         = 1'($urandom_range(0, 1));
            Right        = 1'($urandom_range(0, 1));
            Up           = 1'($urandom_range(0, 1));
            Down         = 1'($urandom_range(0, 1));
            Speed        = 3'($urandom_range(0, 7));
            Collect      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            Deposit      = ($urandom_range(0, 15) == 0);
            Hit          = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Parametrised per-player controller for the heist playfield.
- Movement, facing, bounds clamping, walk/death animation sequencing, item carry and deposit scoring, death penalty and respawn.
- Adds a lives counter, post-respawn invulnerability, a game-over terminal state, item-capacity enforcement and saturating score.
- One instance per player; top level wires keycode bits, collision results and renderer DrawX/DrawY into it.

Parameters:
MAX_ITEMS, 3, carry capacity (1..7)
TILES_PER_ANIM, 8, animation tiles per state
FRAMES_PER_TILE, 5, FrameClk ticks per animation tile
DEATH_TILES, 60, tile periods spent in PENALTY
INVULN_FRAMES, 90, frames of hit immunity after respawn
LIVES, 3, lives at game start
MOVE_DIV, 2, move once every MOVE_DIV frames
MIN_X/MAX_X, 100/739, horizontal playfield bounds
MIN_Y/MAX_Y, 65/448, vertical playfield bounds
P_W/P_H, 32/32, sprite size
SPAWN_X/SPAWN_Y, 292/400, spawn position
SCORE_W, 7, score width

Ports:
FrameClk  in  1  frame-rate clock; the only clock
Reset  in  1  synchronous, active-high
SpawnEnable  in  1  game running; low forces SPAWN and re-arms a full restart
FaceLeftInit  in  1  facing at spawn
Left, Right, Up, Down  in  1 each  direction requests
Hit  in  1  vehicle collision this frame
Collect  in  2  item value picked up this frame (0 = none)
Deposit  in  1  hitbox overlaps heist vehicle
Speed  in  3  base pixels per move
DrawX, DrawY  in  10 each  renderer scan position
PlayerPixel  out  1  scan position inside sprite while active
Tile  out  7  sprite tile index
PixelX, PixelY  out  5 each  sprite-local coordinate, X mirrored when facing left
PlayerX, PlayerY  out  10 each  top-left position
Dead  out  1  state is DYING or PENALTY
Invuln  out  1  immunity window active
Full  out  1  items == MAX_ITEMS
GameOver  out  1  state is OVER
Lives  out  3  remaining lives
Score  out  SCORE_W  banked score

Behaviour:
- Reset:
  - state = SPAWN; all counters, items, value, score = 0; lives = LIVES; position = spawn.
  - All outputs follow from these; PlayerPixel = 0.
- States are SPAWN, IDLE, WALK, DYING, PENALTY, OVER.
- SPAWN:
  - Taken when SpawnEnable = 1.
  - Loads position, facing, items = 0, value = 0, anim counters = 0, invuln counter = INVULN_FRAMES.
  - Clears score and lives only if the previous frame had SpawnEnable = 0.
  - Next state is IDLE, one frame later.
- SpawnEnable = 0 in any state: next state is SPAWN and the restart flag is set.
- Animation:
  - frame counter wraps at FRAMES_PER_TILE-1.
  - On wrap, the tile counter advances and wraps at TILES_PER_ANIM-1.
  - In PENALTY the tile counter holds at its last value.
- IDLE/WALK:
  - Each frame, decrement invuln if nonzero; Invuln = (invuln != 0).
  - A move counter fires every MOVE_DIV frames.
  - On a firing frame:
    - Left XOR Right moves X and sets facing; both or neither leaves X unchanged.
    - Up XOR Down moves Y likewise.
    - state = WALK if any axis moved, else IDLE.
  - Non-firing frame: state holds.
  - Step = max(Speed - items, 1).
  - Clamp X to [MIN_X, MAX_X - P_W] and Y to [MIN_Y, MAX_Y - P_H].
  - Compute in 11 bits so no wrap below 0.
- Collect:
  - Nonzero and items < MAX_ITEMS: items += 1, value += Collect.
  - Otherwise ignored.
- Deposit:
  - score = min(score + value + accepted Collect, 2^SCORE_W - 1); items = value = 0 the same frame.
- Hit:
  - Only acts in IDLE/WALK with Invuln = 0; it has priority over movement, collect and deposit that frame.
  - Sets state = DYING and zeros the anim counters.
  - Carried items are lost and lives decrement by 1.
- DYING → PENALTY on the last tile wrap.
- PENALTY:
  - Counts DEATH_TILES tile periods.
  - Then goes to SPAWN if lives > 0, else OVER.
  - A second Hit is ignored.
- OVER is terminal until SpawnEnable = 0 or Reset.
- Outputs (combinational):
  - PlayerPixel = active && PlayerX ≤ DrawX < PlayerX+P_W && same on Y; active excludes SPAWN and OVER.
  - Tile = anim_row·TILES_PER_ANIM·(MAX_ITEMS+1) + tile·(MAX_ITEMS+1) + items, with anim_row IDLE=0, WALK=1, DYING=2, PENALTY=3.
  - PixelX = facing ? P_W-1-(DrawX-PlayerX) : DrawX-PlayerX.
- Reset mid-death or mid-invulnerability: everything returns to reset values the next edge.

Decomposition:
- Package player_pkg holds:
  - the state enum;
  - default bound, spawn and timing constants;
  - the tile-index function.
- Sub-module anim_counter (frame/tile divider with hold input and wrap strobe), reused later for vehicles.

Test Plan:
- Reset, SpawnEnable=1, Speed=4, Right held 10 frames, MOVE_DIV=2 → X = 292+20 = 312, WALK, facing right; release → IDLE on next move tick.
- Start X=104, Left, Speed=6 → X clamps to 100, never wraps; Down held from Y=410 → Y clamps to 416.
- Collect 2,1,1,3 on successive frames, MAX_ITEMS=3 → items = 3, value = 4, Full = 1, fourth ignored; step = max(4-3, 1) = 1; Deposit → Score = 4, items = 0.
- Hit at frame 10 after spawn (Invuln=1) → ignored; Hit at frame 95 → DYING, lives 3→2, items cleared.
- Death sequence → DYING 40 frames, PENALTY 300 frames, then SPAWN at (292,400) with score kept.
- Lives=1 then Hit → OVER after penalty, GameOver=1, PlayerPixel=0. SpawnEnable 0→1 then restores lives=3, score=0. Score at 126 plus deposit of 5 → Score saturates at 127.
